// File: rtl/mire_pkg.sv
// mire_pkg: pixel format, colour constants and FSM states shared by the mire pattern generator.
package mire_pkg;
   typedef struct packed {
      logic [7:0] pad;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pixel_t;
   typedef enum logic [31:0] {
      BLACK   = 32'h00000000,
      WHITE   = 32'h00FFFFFF,
      YELLOW  = 32'h00FFFF00,
      CYAN    = 32'h0000FFFF,
      GREEN   = 32'h0000FF00,
      MAGENTA = 32'h00FF00FF,
      RED     = 32'h00FF0000,
      BLUE    = 32'h000000FF
   } colour_e;
   typedef enum logic {WRITE, PAUSE} state_t;
endpackage

// File: rtl/mire_pattern.sv
// mire_pattern: maps raster position to a pixel; grid by default, eight colour bars when MIRE_COLOR_EN is defined.
module mire_pattern
   import mire_pkg::*;
(
   output pixel_t     pix,
`ifdef MIRE_COLOR_EN
   input  logic [2:0] bar
`else
   input  logic [3:0] x,
   input  logic [3:0] y
`endif
);
`ifdef MIRE_COLOR_EN
   localparam pixel_t BARS [8] = '{WHITE, YELLOW, CYAN, GREEN, MAGENTA, RED, BLUE, BLACK};
   assign pix = BARS[bar];
`else
   assign pix = (x == 4'd0 || y == 4'd0) ? pixel_t'(WHITE) : pixel_t'(BLACK);
`endif
endmodule

// File: rtl/mire_gen.sv
// mire_gen: Wishbone master painting a test pattern into the framebuffer in raster order.
// Define MIRE_COLOR_EN for colour bars instead of the default grid.
module mire_gen
   import mire_pkg::*;
#(
   parameter int HDISP     = 800,
   parameter int VDISP     = 480,
   parameter int BURST_LEN = 64
) (
   input  logic        clk,
   input  logic        rst,
   output logic        cyc,
   output logic        stb,
   output logic        we,
   output logic [31:0] adr,
   output logic [31:0] dat_ms,
   output logic [3:0]  sel,
   output logic [2:0]  cti,
   output logic [1:0]  bte,
   input  logic        ack,
   input  logic        err,
   input  logic        rty,
   input  logic [31:0] dat_sm
);
   localparam int NPIX = HDISP * VDISP;
   localparam int XW = $clog2(HDISP);
   localparam int YW = $clog2(VDISP);
   localparam int PW = $clog2(NPIX);
   localparam int BW = $clog2(BURST_LEN);
   localparam logic [XW-1:0] X_LAST = XW'(HDISP - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(VDISP - 1);
   localparam logic [PW-1:0] P_LAST = PW'(NPIX - 1);
   localparam logic [BW-1:0] B_LAST = BW'(BURST_LEN - 1);

   state_t state;
   logic [XW-1:0] x, nx;
   logic [YW-1:0] y, ny;
   logic [PW-1:0] pix, npix;
   logic [BW-1:0] bc;
   logic adv;
   pixel_t pat;
   // err and rty leave the transfer pending; only ack moves the raster on
   logic unused;

   assign unused = ^{err, rty, dat_sm};
   assign we = 1'b1;
   assign sel = 4'hF;
   assign cti = 3'b000;
   assign bte = 2'b00;
   assign adv = state == WRITE && ack;

   always_comb begin
      nx = adv ? (x == X_LAST ? '0 : x + 1'b1) : x;
      ny = adv && x == X_LAST ? (y == Y_LAST ? '0 : y + 1'b1) : y;
      npix = adv ? (pix == P_LAST ? '0 : pix + 1'b1) : pix;
   end

`ifdef MIRE_COLOR_EN
   localparam int CW = $clog2(HDISP / 8 + 1);
   localparam logic [CW-1:0] C_LAST = CW'(HDISP / 8 - 1);
   logic [CW-1:0] cnt, ncnt;
   logic [2:0] bar, nbar;

   // bar index tracks x through a per-bar pixel counter instead of dividing
   always_comb begin
      ncnt = adv ? (x == X_LAST || cnt == C_LAST ? '0 : cnt + 1'b1) : cnt;
      nbar = adv ? (x == X_LAST ? '0 : bar + {2'b00, cnt == C_LAST}) : bar;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         bar <= '0;
      end else begin
         cnt <= ncnt;
         bar <= nbar;
      end
   end

   mire_pattern u_pattern (.pix(pat), .bar(nbar));
`else
   mire_pattern u_pattern (.pix(pat), .x(nx[3:0]), .y(ny[3:0]));
`endif

   // outputs are loaded from the next-position values so adr and dat_ms stay aligned
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= PAUSE;
         cyc <= 1'b0;
         stb <= 1'b0;
         adr <= '0;
         dat_ms <= '0;
         x <= '0;
         y <= '0;
         pix <= '0;
         bc <= '0;
      end else begin
         x <= nx;
         y <= ny;
         pix <= npix;
         adr <= 32'({npix, 2'b00});
         dat_ms <= pat;
         if (state == PAUSE) begin
            state <= WRITE;
            cyc <= 1'b1;
            stb <= 1'b1;
         end else if (adv && bc == B_LAST) begin
            state <= PAUSE;
            cyc <= 1'b0;
            stb <= 1'b0;
            bc <= '0;
         end else if (adv) begin
            bc <= bc + 1'b1;
         end
      end
   end
endmodule
